// File: rtl/ppa_result_checker.sv
// ---------------------------------------------------------------------------
// ppa_result_checker
//
// Self-check stage that sits after a pipelined parallel-prefix adder. It taps
// the operands driven into the adder, computes the golden A+B+Cin result,
// delays it LATENCY cycles so it lines up with the adder's registered output,
// then compares and tallies passes/failures over a programmed run. The first
// mismatch is captured (index, expected value, received value).
//
// Parameters:
//   WIDTH    operand / sum width
//   LATENCY  clk edges from operand sample to adder result sample (>= 1)
//   CNT_W    width of the vector and index counters
//
// Ports:
//   clk            rising-edge clock shared with the adder
//   rst            asynchronous active-high reset
//   start          one-cycle pulse, begins a run when idle
//   num_vectors    vectors in the run, sampled on start
//   op_valid       operands on this cycle form a counted vector
//   op_a, op_b     operands (same values driven to the adder)
//   op_cin         carry-in (same value driven to the adder)
//   dut_sum        adder Sum output
//   dut_cout       adder Cout output
//   busy           high while running or draining
//   done           one-cycle pulse at the end of a run
//   pass_cnt       matching vectors (saturating)
//   fail_cnt       mismatching vectors (saturating)
//   err_flag       sticky, set on the first mismatch
//   first_err_idx  index of the first mismatching vector
//   first_err_exp  {cout,sum} expected at the first mismatch
//   first_err_got  {cout,sum} received at the first mismatch
//
// Build option:
//   PPA_CHECK_STOP_ON_ERR_EN  when defined, the first mismatch ends the run on
//                             the next edge and in-flight vectors are dropped.
// ---------------------------------------------------------------------------
module ppa_result_checker #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_flag,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH:0]   first_err_exp,
    output logic [WIDTH:0]   first_err_got
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef PPA_CHECK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] nvec_q;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] checked;

    logic             vld_q [LATENCY];
    logic [WIDTH:0]   exp_q [LATENCY];

    logic [WIDTH:0]   golden;
    logic [WIDTH:0]   got;
    logic             start_run;
    logic             accept;
    logic             last_issue;
    logic             compare_en;
    logic             match;
    logic             mismatch;
    logic             last_check;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Golden result is computed one bit wider so the carry lands in the MSB.
    assign golden = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
    assign got    = {dut_cout, dut_sum};

    assign start_run  = (state == IDLE) && start;
    assign accept     = (state == RUN) && op_valid && (issued < nvec_q);
    assign last_issue = accept && (issued == nvec_q - CNT_ONE);

    // The tap is the last delay stage; compares are only honoured while a run
    // is active so stale entries after a stop-on-error are never counted.
    assign compare_en = vld_q[LATENCY-1] && ((state == RUN) || (state == DRAIN));
    assign match      = (got == exp_q[LATENCY-1]);
    assign mismatch   = compare_en && !match;
    assign last_check = compare_en && (checked == nvec_q - CNT_ONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (STOP_ON_ERR && mismatch) begin
                    state_nxt = DONE;
                end else if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if ((STOP_ON_ERR && mismatch) || last_check) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Golden-result delay line. Valid bits are flushed when a new run starts
    // so nothing left over from an aborted or stopped run can be compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                exp_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            exp_q[0] <= golden;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
            if (start_run) begin
                for (int i = 0; i < LATENCY; i++) begin
                    vld_q[i] <= 1'b0;
                end
            end
        end
    end

    // Run bookkeeping, tallies and first-error capture. Results hold while
    // idle and are only cleared by the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nvec_q        <= '0;
            issued        <= '0;
            checked       <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            err_flag      <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (start_run) begin
            nvec_q        <= num_vectors;
            issued        <= '0;
            checked       <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            err_flag      <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            if (accept) begin
                issued <= sat_inc(issued);
            end
            if (compare_en) begin
                checked <= sat_inc(checked);
                if (match) begin
                    pass_cnt <= sat_inc(pass_cnt);
                end else begin
                    fail_cnt <= sat_inc(fail_cnt);
                    if (!err_flag) begin
                        err_flag      <= 1'b1;
                        first_err_idx <= checked;
                        first_err_exp <= exp_q[LATENCY-1];
                        first_err_got <= got;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ppa_result_checker.sv
// ---------------------------------------------------------------------------
// tb_ppa_result_checker
//
// Drives directed operand runs into ppa_result_checker alongside a simple
// 8-stage behavioural adder (with an optional stuck-at-0 fault on sum[15]).
// Expected run results are hand-computed and queued when each run starts; a
// monitor pops and compares them whenever the checker pulses done.
// ---------------------------------------------------------------------------
module tb_ppa_result_checker;

    localparam int WIDTH   = 16;
    localparam int LATENCY = 8;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             op_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_cout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err_flag;
    logic [CNT_W-1:0] first_err_idx;
    logic [WIDTH:0]   first_err_exp;
    logic [WIDTH:0]   first_err_got;

    typedef struct {
        bit          v;
        bit          st;
        logic [15:0] a;
        logic [15:0] b;
        bit          cin;
    } vec_t;

    typedef struct {
        int          e_pass;
        int          e_fail;
        bit          e_err;
        int          e_idx;
        logic [16:0] e_exp;
        logic [16:0] e_got;
        int          e_off;
        int          start_edge;
    } exp_t;

    vec_t stim_q[$];
    exp_t sb_q[$];

    int tests_run   = 0;
    int fail_count  = 0;
    int cyc         = 0;
    int busy_cycles = 0;
    bit fault       = 1'b0;

    bit [16:0] adder_pipe [LATENCY];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural pipelined adder standing in for the real prefix adder.
    always @(posedge clk) begin
        adder_pipe[0] <= {1'b0, op_a} + {1'b0, op_b} + {16'd0, op_cin};
        for (int i = 1; i < LATENCY; i++) begin
            adder_pipe[i] <= adder_pipe[i-1];
        end
    end

    assign dut_sum  = fault ? (adder_pipe[LATENCY-1][15:0] & 16'h7FFF) : adder_pipe[LATENCY-1][15:0];
    assign dut_cout = adder_pipe[LATENCY-1][16];

    ppa_result_checker #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_vectors   (num_vectors),
        .op_valid      (op_valid),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_cin        (op_cin),
        .dut_sum       (dut_sum),
        .dut_cout      (dut_cout),
        .busy          (busy),
        .done          (done),
        .pass_cnt      (pass_cnt),
        .fail_cnt      (fail_cnt),
        .err_flag      (err_flag),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
    );

    task automatic checkOutput(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    task automatic addVec(input bit v, input logic [15:0] a, input logic [15:0] b,
                          input bit cin, input bit st);
        vec_t e;
        e.v   = v;
        e.a   = a;
        e.b   = b;
        e.cin = cin;
        e.st  = st;
        stim_q.push_back(e);
    endtask

    // Starts a run with n vectors (start cycle carries a junk valid vector),
    // queues the expected result, plays stim_q and waits for done.
    task automatic applyStimulus(input int n, input int e_pass, input int e_fail,
                                 input bit e_err, input int e_idx,
                                 input logic [16:0] e_exp, input logic [16:0] e_got,
                                 input int e_off);
        exp_t r;
        int   waited;
        @(negedge clk);
        start       = 1'b1;
        num_vectors = CNT_W'(n);
        op_valid    = 1'b1;
        op_a        = 16'hDEAD;
        op_b        = 16'hBEEF;
        op_cin      = 1'b1;
        @(posedge clk);
        #1;
        r.e_pass     = e_pass;
        r.e_fail     = e_fail;
        r.e_err      = e_err;
        r.e_idx      = e_idx;
        r.e_exp      = e_exp;
        r.e_got      = e_got;
        r.e_off      = e_off;
        r.start_edge = cyc;
        sb_q.push_back(r);
        @(negedge clk);
        start       = 1'b0;
        num_vectors = 16'h0007;
        op_valid    = 1'b0;
        foreach (stim_q[i]) begin
            op_valid = stim_q[i].v;
            op_a     = stim_q[i].a;
            op_b     = stim_q[i].b;
            op_cin   = stim_q[i].cin;
            start    = stim_q[i].st;
            if (stim_q[i].st) num_vectors = 16'd5;
            @(negedge clk);
            start = 1'b0;
        end
        op_valid = 1'b0;
        stim_q.delete();
        waited = 0;
        while (!done && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!done) begin
            tests_run++;
            fail_count++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 100 cycles");
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor: compares the queued expectation on every done pulse.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    tests_run++;
                    fail_count++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected done=0");
                end else begin
                    r = sb_q.pop_front();
                    checkOutput("pass_cnt",      32'(pass_cnt),      32'(r.e_pass));
                    checkOutput("fail_cnt",      32'(fail_cnt),      32'(r.e_fail));
                    checkOutput("err_flag",      32'(err_flag),      32'(r.e_err));
                    checkOutput("first_err_idx", 32'(first_err_idx), 32'(r.e_idx));
                    checkOutput("first_err_exp", 32'(first_err_exp), 32'(r.e_exp));
                    checkOutput("first_err_got", 32'(first_err_got), 32'(r.e_got));
                    checkOutput("done_offset",   32'(cyc - r.start_edge), 32'(r.e_off));
                    checkOutput("busy_at_done",  32'(busy),          32'd0);
                end
            end
        end
    end

    initial begin
        int busy_before;
        rst         = 1'b1;
        start       = 1'b0;
        num_vectors = '0;
        op_valid    = 1'b0;
        op_a        = '0;
        op_b        = '0;
        op_cin      = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_busy",          32'(busy),          32'd0);
        checkOutput("rst_done",          32'(done),          32'd0);
        checkOutput("rst_pass_cnt",      32'(pass_cnt),      32'd0);
        checkOutput("rst_fail_cnt",      32'(fail_cnt),      32'd0);
        checkOutput("rst_err_flag",      32'(err_flag),      32'd0);
        checkOutput("rst_first_err_idx", 32'(first_err_idx), 32'd0);
        checkOutput("rst_first_err_exp", 32'(first_err_exp), 32'd0);
        checkOutput("rst_first_err_got", 32'(first_err_got), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] golden run, 4 back-to-back vectors");
        addVec(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        addVec(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        addVec(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0);
        addVec(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0);
        applyStimulus(4, 4, 0, 1'b0, 0, 17'h0, 17'h0, 4 + LATENCY);

        repeat (5) @(negedge clk);
        checkOutput("hold_pass_cnt", 32'(pass_cnt), 32'd4);
        checkOutput("hold_busy",     32'(busy),     32'd0);

        $display("[TB] faulty adder, sum[15] stuck at 0");
        fault = 1'b1;
        addVec(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        addVec(1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0);
        addVec(1'b1, 16'hC000, 16'h0000, 1'b0, 1'b0);
`ifdef PPA_CHECK_STOP_ON_ERR_EN
        applyStimulus(3, 1, 1, 1'b1, 1, 17'h08000, 17'h00000, 2 + LATENCY);
`else
        applyStimulus(3, 1, 2, 1'b1, 1, 17'h08000, 17'h00000, 3 + LATENCY);
`endif
        fault = 1'b0;

        $display("[TB] gapped input 1,0,0,1,0,1");
        addVec(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
        addVec(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        addVec(1'b0, 16'h3333, 16'h4444, 1'b1, 1'b0);
        addVec(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        addVec(1'b0, 16'h5555, 16'h6666, 1'b0, 1'b0);
        addVec(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        applyStimulus(3, 3, 0, 1'b0, 0, 17'h0, 17'h0, 6 + LATENCY);

        $display("[TB] zero-length run");
        busy_before = busy_cycles;
        applyStimulus(0, 0, 0, 1'b0, 0, 17'h0, 17'h0, 0);
        checkOutput("zero_run_busy_cycles", 32'(busy_cycles - busy_before), 32'd0);

        $display("[TB] start pulse during run");
        addVec(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0);
        addVec(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
        addVec(1'b1, 16'h00FF, 16'hFF00, 1'b0, 1'b0);
        applyStimulus(3, 3, 0, 1'b0, 0, 17'h0, 17'h0, 3 + LATENCY);

        $display("[TB] reset mid-run");
        @(negedge clk);
        start       = 1'b1;
        num_vectors = 16'd10;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_valid = 1'b1;
            op_a     = 16'(i * 3);
            op_b     = 16'(i + 7);
            op_cin   = 1'b0;
            @(negedge clk);
        end
        checkOutput("busy_before_abort", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy",     32'(busy),     32'd0);
        checkOutput("abort_done",     32'(done),     32'd0);
        checkOutput("abort_pass_cnt", 32'(pass_cnt), 32'd0);
        checkOutput("abort_fail_cnt", 32'(fail_cnt), 32'd0);
        checkOutput("abort_err_flag", 32'(err_flag), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        op_valid = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("abort_idle_busy", 32'(busy), 32'd0);
        addVec(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0);
        addVec(1'b1, 16'hFFFE, 16'h0001, 1'b1, 1'b0);
        applyStimulus(2, 2, 0, 1'b0, 0, 17'h0, 17'h0, 2 + LATENCY);

`ifdef PPA_CHECK_STOP_ON_ERR_EN
        $display("[TB] stop on first error, 5 vectors with 2nd failing");
        fault = 1'b1;
        addVec(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        addVec(1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0);
        addVec(1'b1, 16'h0002, 16'h0003, 1'b0, 1'b0);
        addVec(1'b1, 16'hC000, 16'h0000, 1'b0, 1'b0);
        addVec(1'b1, 16'h0004, 16'h0004, 1'b1, 1'b0);
        applyStimulus(5, 1, 1, 1'b1, 1, 17'h08000, 17'h00000, 2 + LATENCY);
        fault = 1'b0;
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
